// File: rtl/instr_reg_n_pkg.sv
// Shared types and helpers for the instruction register (package ir_pkg).
// Holds the command/state enums and the lane-index width helper.
package ir_pkg;

    typedef enum logic [2:0] {
        IR_CLR  = 3'b000,
        IR_LOAD = 3'b001,
        IR_DEC  = 3'b010,
        IR_INC  = 3'b011,
        IR_AUTO = 3'b100
    } ir_funsel_e;

    typedef enum logic [1:0] {
        IR_IDLE = 2'd0,
        IR_FILL = 2'd1,
        IR_DONE = 2'd2
    } ir_state_e;

    // A single-lane register still needs a 1-bit lane index port.
    function automatic int lane_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/instr_reg_n_if.sv
// Command/data bus between memory data path, control unit and instr_reg_n.
// Optional macro IR_PARITY_EN adds InParity / ParErr.
interface instr_reg_n_if #(
    parameter int BYTE_W    = 8,
    parameter int NUM_BYTES = 2
);
    import ir_pkg::*;

    localparam int OUT_W  = BYTE_W * NUM_BYTES;
    localparam int LANE_W = lane_w(NUM_BYTES);

    logic              E;
    logic [2:0]        FunSel;
    logic [LANE_W-1:0] Lane;
    logic [BYTE_W-1:0] Input;
    logic              InValid;
    logic [OUT_W-1:0]  IROut;
    logic              Ready;
    logic              Busy;
    logic [LANE_W-1:0] ByteCnt;
`ifdef IR_PARITY_EN
    logic              InParity;
    logic              ParErr;

    modport master (
        output E, FunSel, Lane, Input, InValid, InParity,
        input  IROut, Ready, Busy, ByteCnt, ParErr
    );
    modport slave (
        input  E, FunSel, Lane, Input, InValid, InParity,
        output IROut, Ready, Busy, ByteCnt, ParErr
    );
`else
    modport master (
        output E, FunSel, Lane, Input, InValid,
        input  IROut, Ready, Busy, ByteCnt
    );
    modport slave (
        input  E, FunSel, Lane, Input, InValid,
        output IROut, Ready, Busy, ByteCnt
    );
`endif

endinterface

// File: rtl/instr_reg_n_fill_ctrl.sv
// Auto-fill sequencer: IDLE/FILL/DONE FSM, byte counter and lane-write strobe.
// Busy/Ready are registered alongside the state so outputs never glitch.
module ir_fill_ctrl
    import ir_pkg::*;
#(
    parameter  int NUM_BYTES = 2,
    localparam int LANE_W    = lane_w(NUM_BYTES)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              E,
    input  logic [2:0]        FunSel,
    input  logic              InValid,
    output logic              busy,
    output logic              ready,
    output logic [LANE_W-1:0] byte_cnt,
    output logic              fill_wr,
    output logic [LANE_W-1:0] fill_lane
);

    ir_state_e  state;
    ir_funsel_e cmd;
    logic       abort;
    logic       last_lane;

    assign cmd       = ir_funsel_e'(FunSel);
    assign abort     = E && (cmd == IR_CLR);
    assign last_lane = (byte_cnt == LANE_W'(NUM_BYTES - 1));
    // A clear in the same cycle as a valid byte wins, so the byte is dropped.
    assign fill_wr   = (state == IR_FILL) && InValid && !abort;
    assign fill_lane = byte_cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IR_IDLE;
            busy     <= 1'b0;
            ready    <= 1'b0;
            byte_cnt <= '0;
        end else begin
            case (state)
                IR_FILL: begin
                    if (abort) begin
                        state    <= IR_IDLE;
                        busy     <= 1'b0;
                        byte_cnt <= '0;
                    end else if (InValid) begin
                        if (last_lane) begin
                            state    <= IR_DONE;
                            busy     <= 1'b0;
                            ready    <= 1'b1;
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + LANE_W'(1);
                        end
                    end
                end
                default: begin
                    if (E) begin
                        case (cmd)
                            IR_CLR, IR_LOAD, IR_DEC, IR_INC: begin
                                state <= IR_IDLE;
                                ready <= 1'b0;
                            end
                            IR_AUTO: begin
                                state    <= IR_FILL;
                                busy     <= 1'b1;
                                ready    <= 1'b0;
                                byte_cnt <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_reg_n.sv
// Byte-lane instruction register with clear/load/inc/dec and a sequenced auto-fill.
// Optional macro IR_PARITY_EN adds even-parity checking of auto-fill bytes (sticky ParErr).
module instr_reg_n
    import ir_pkg::*;
#(
    parameter int BYTE_W    = 8,
    parameter int NUM_BYTES = 2
) (
    input  logic          Clock,
    input  logic          Reset,
    instr_reg_n_if.slave  bus
);

    localparam int OUT_W  = BYTE_W * NUM_BYTES;
    localparam int LANE_W = lane_w(NUM_BYTES);

    logic [OUT_W-1:0]  ir_q;
    logic [OUT_W-1:0]  ir_d;
    logic              fill_busy;
    logic              fill_ready;
    logic [LANE_W-1:0] byte_cnt;
    logic              fill_wr;
    logic [LANE_W-1:0] fill_lane;
    logic              lane_en;
    logic [LANE_W-1:0] lane_sel;
    ir_funsel_e        cmd;
    logic              abort;

    assign cmd   = ir_funsel_e'(bus.FunSel);
    assign abort = bus.E && (cmd == IR_CLR);

    ir_fill_ctrl #(.NUM_BYTES(NUM_BYTES)) u_fill_ctrl (
        .Clock    (Clock),
        .Reset    (Reset),
        .E        (bus.E),
        .FunSel   (bus.FunSel),
        .InValid  (bus.InValid),
        .busy     (fill_busy),
        .ready    (fill_ready),
        .byte_cnt (byte_cnt),
        .fill_wr  (fill_wr),
        .fill_lane(fill_lane)
    );

    // While filling, only abort and the sequencer's lane writes touch the word.
    always_comb begin
        ir_d     = ir_q;
        lane_en  = 1'b0;
        lane_sel = bus.Lane;
        if (fill_busy) begin
            if (abort) begin
                ir_d = '0;
            end else if (fill_wr) begin
                lane_en  = 1'b1;
                lane_sel = fill_lane;
            end
        end else if (bus.E) begin
            case (cmd)
                IR_CLR, IR_AUTO: ir_d = '0;
                IR_LOAD:         lane_en = 1'b1;
                IR_DEC:          ir_d = ir_q - OUT_W'(1);
                IR_INC:          ir_d = ir_q + OUT_W'(1);
                default: ;
            endcase
        end
        // Out-of-range lane indices match no lane and so write nothing.
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (lane_en && (lane_sel == LANE_W'(i))) begin
                ir_d[i*BYTE_W +: BYTE_W] = bus.Input;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

    assign bus.IROut   = ir_q;
    assign bus.Ready   = fill_ready;
    assign bus.Busy    = fill_busy;
    assign bus.ByteCnt = byte_cnt;

`ifdef IR_PARITY_EN
    logic par_err_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            par_err_q <= 1'b0;
        end else if (fill_busy) begin
            if (abort) begin
                par_err_q <= 1'b0;
            end else if (fill_wr && ((^bus.Input) != bus.InParity)) begin
                par_err_q <= 1'b1;
            end
        end else if (bus.E && ((cmd == IR_CLR) || (cmd == IR_AUTO))) begin
            par_err_q <= 1'b0;
        end
    end

    assign bus.ParErr = par_err_q;
`endif

endmodule

// File: tb/tb_instr_reg_n.sv
// Self-checking bench for instr_reg_n: vector table, hand sequences and a random run vs. a reference model.
module tb_instr_reg_n;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    instr_reg_n_if #(.BYTE_W(8), .NUM_BYTES(2)) b2 ();
    instr_reg_n_if #(.BYTE_W(8), .NUM_BYTES(3)) b3 ();
    instr_reg_n_if #(.BYTE_W(8), .NUM_BYTES(4)) b4 ();

    instr_reg_n #(.BYTE_W(8), .NUM_BYTES(2)) u2 (.Clock(Clock), .Reset(Reset), .bus(b2));
    instr_reg_n #(.BYTE_W(8), .NUM_BYTES(3)) u3 (.Clock(Clock), .Reset(Reset), .bus(b3));
    instr_reg_n #(.BYTE_W(8), .NUM_BYTES(4)) u4 (.Clock(Clock), .Reset(Reset), .bus(b4));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       e;
        logic [2:0] fs;
        logic       lane;
        logic [7:0] din;
        logic       inv;
        logic [15:0] ir;
        logic       busy;
        logic       ready;
        logic       cnt;
    } vec_t;

    vec_t tbl[$];

    logic [7:0]  seq_din [7] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h04};
    logic        seq_vld [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] seq_ir  [7] = '{32'h01, 32'h0201, 32'h0201, 32'h0201, 32'h0201,
                                 32'h030201, 32'h04030201};
    logic [1:0]  seq_cnt [7] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void add(input string n, input logic rst, input logic e,
                                input logic [2:0] fs, input logic lane, input logic [7:0] din,
                                input logic inv, input logic [15:0] ir, input logic busy,
                                input logic ready, input logic cnt);
        vec_t v;
        v.name = n; v.rst = rst; v.e = e; v.fs = fs; v.lane = lane; v.din = din;
        v.inv = inv; v.ir = ir; v.busy = busy; v.ready = ready; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    task automatic drive2(input logic rst, input logic e, input logic [2:0] fs,
                          input logic lane, input logic [7:0] din, input logic inv,
                          input logic par);
        @(negedge Clock);
        Reset      = rst;
        b2.E       = e;
        b2.FunSel  = fs;
        b2.Lane    = lane;
        b2.Input   = din;
        b2.InValid = inv;
`ifdef IR_PARITY_EN
        b2.InParity = par;
`else
        if (par) ;
`endif
        @(posedge Clock);
        #1;
    endtask

    // Reference model state: plain word value plus "filling"/"ready" flags and bytes-received count.
    int unsigned m_ir;
    bit          m_fill;
    bit          m_ready;
    int          m_cnt;
    bit          m_perr;

    task automatic model_step(input bit rst, input bit e, input int fs, input int lane,
                              input int din, input bit inv, input bit par);
        if (rst) begin
            m_ir = 0; m_fill = 0; m_ready = 0; m_cnt = 0; m_perr = 0;
        end else if (m_fill) begin
            if (e && fs == 0) begin
                m_ir = 0; m_fill = 0; m_cnt = 0; m_perr = 0;
            end else if (inv) begin
                m_ir = (m_ir & ~(32'hFF << (8 * m_cnt))) | (din << (8 * m_cnt));
                if ($countones(din[7:0]) % 2 != int'(par)) m_perr = 1;
                m_cnt++;
                if (m_cnt == 2) begin
                    m_cnt = 0; m_fill = 0; m_ready = 1;
                end
            end
        end else if (e) begin
            case (fs)
                0: begin m_ir = 0; m_ready = 0; m_perr = 0; end
                1: begin
                    if (lane < 2) m_ir = (m_ir & ~(32'hFF << (8 * lane))) | (din << (8 * lane));
                    m_ready = 0;
                end
                2: begin m_ir = (m_ir + 65535) % 65536; m_ready = 0; end
                3: begin m_ir = (m_ir + 1) % 65536; m_ready = 0; end
                4: begin m_ir = 0; m_cnt = 0; m_fill = 1; m_ready = 0; m_perr = 0; end
                default: ;
            endcase
        end
    endtask

    initial begin
        b2.E = 0; b2.FunSel = 0; b2.Lane = 0; b2.Input = 0; b2.InValid = 0;
        b3.E = 0; b3.FunSel = 0; b3.Lane = 0; b3.Input = 0; b3.InValid = 0;
        b4.E = 0; b4.FunSel = 0; b4.Lane = 0; b4.Input = 0; b4.InValid = 0;
`ifdef IR_PARITY_EN
        b2.InParity = 0; b3.InParity = 0; b4.InParity = 0;
`endif

        //   name               rst e  fs    ln din    inv ir        bsy rdy cnt
        add("reset",            1, 0, 3'd0, 0, 8'h00, 0, 16'h0000, 0, 0, 0);
        add("load_lane1",       0, 1, 3'd1, 1, 8'h12, 0, 16'h1200, 0, 0, 0);
        add("load_lane0",       0, 1, 3'd1, 0, 8'h34, 0, 16'h1234, 0, 0, 0);
        add("load_ff_hi",       0, 1, 3'd1, 1, 8'hFF, 0, 16'hFF34, 0, 0, 0);
        add("load_ff_lo",       0, 1, 3'd1, 0, 8'hFF, 0, 16'hFFFF, 0, 0, 0);
        add("inc_wrap",         0, 1, 3'd3, 0, 8'h00, 0, 16'h0000, 0, 0, 0);
        add("dec_wrap",         0, 1, 3'd2, 0, 8'h00, 0, 16'hFFFF, 0, 0, 0);
        add("e0_hold",          0, 0, 3'd3, 0, 8'h00, 0, 16'hFFFF, 0, 0, 0);
        add("fs5_hold",         0, 1, 3'd5, 0, 8'h00, 0, 16'hFFFF, 0, 0, 0);
        add("auto_start",       0, 1, 3'd4, 0, 8'h00, 0, 16'h0000, 1, 0, 0);
        add("fill_b0",          0, 0, 3'd0, 0, 8'hAA, 1, 16'h00AA, 1, 0, 1);
        add("rst_midfill",      1, 0, 3'd0, 0, 8'h00, 0, 16'h0000, 0, 0, 0);
        add("auto_start2",      0, 1, 3'd4, 0, 8'h00, 0, 16'h0000, 1, 0, 0);
        add("fill_ignore_inc",  0, 1, 3'd3, 0, 8'h55, 1, 16'h0055, 1, 0, 1);
        add("abort_same_cyc",   0, 1, 3'd0, 0, 8'h77, 1, 16'h0000, 0, 0, 0);
        add("auto_start3",      0, 1, 3'd4, 0, 8'h00, 0, 16'h0000, 1, 0, 0);
        add("fill_lo",          0, 0, 3'd0, 0, 8'h11, 1, 16'h0011, 1, 0, 1);
        add("fill_done",        0, 0, 3'd0, 0, 8'h22, 1, 16'h2211, 0, 1, 0);
        add("done_e0_hold",     0, 0, 3'd3, 0, 8'h00, 1, 16'h2211, 0, 1, 0);
        add("done_fs6_hold",    0, 1, 3'd6, 0, 8'h00, 0, 16'h2211, 0, 1, 0);
        add("ready_clear_inc",  0, 1, 3'd3, 0, 8'h00, 0, 16'h2212, 0, 0, 0);

        foreach (tbl[i]) begin
            drive2(tbl[i].rst, tbl[i].e, tbl[i].fs, tbl[i].lane, tbl[i].din, tbl[i].inv, 1'b0);
            chk(tbl[i].name, {b2.IROut, b2.Busy, b2.Ready, b2.ByteCnt},
                {tbl[i].ir, tbl[i].busy, tbl[i].ready, tbl[i].cnt});
        end
        b2.E = 0; b2.InValid = 0;

        // Four-lane auto-fill with a three-cycle stall between bytes 2 and 3.
        @(negedge Clock);
        b4.E = 1; b4.FunSel = 3'b100; b4.InValid = 0;
        @(posedge Clock); #1;
        chk("fill4_start", {b4.IROut, b4.Busy, b4.Ready}, {32'h0, 1'b1, 1'b0});
        for (int i = 0; i < 7; i++) begin
            @(negedge Clock);
            b4.E = 0; b4.Input = seq_din[i]; b4.InValid = seq_vld[i];
            @(posedge Clock); #1;
            chk($sformatf("fill4_step%0d", i), {b4.IROut, b4.Busy, b4.Ready, b4.ByteCnt},
                {seq_ir[i], (i < 6) ? 1'b1 : 1'b0, (i == 6) ? 1'b1 : 1'b0, seq_cnt[i]});
        end
        @(negedge Clock); b4.InValid = 0;

        // Three-lane part: lane index 3 is representable but out of range.
        @(negedge Clock);
        b3.E = 1; b3.FunSel = 3'b001; b3.Lane = 2'd0; b3.Input = 8'hAB;
        @(posedge Clock); #1;
        chk("load3_lane0", 64'(b3.IROut), 64'h0000AB);
        @(negedge Clock); b3.Lane = 2'd3; b3.Input = 8'hCD;
        @(posedge Clock); #1;
        chk("load3_lane_oob", 64'(b3.IROut), 64'h0000AB);
        @(negedge Clock); b3.Lane = 2'd2; b3.Input = 8'hCD;
        @(posedge Clock); #1;
        chk("load3_lane2", 64'(b3.IROut), 64'hCD00AB);
        @(negedge Clock); b3.E = 0;

`ifdef IR_PARITY_EN
        drive2(0, 1, 3'd4, 0, 8'h00, 0, 1'b0);
        drive2(0, 0, 3'd0, 0, 8'h01, 1, 1'b1);
        chk("par_good_byte", 64'(b2.ParErr), 64'd0);
        drive2(0, 0, 3'd0, 0, 8'h02, 1, 1'b0);
        chk("par_bad_byte", {b2.ParErr, b2.Ready, b2.IROut}, {1'b1, 1'b1, 16'h0201});
        drive2(0, 0, 3'd0, 0, 8'h00, 0, 1'b0);
        chk("par_sticky_done", {b2.ParErr, b2.Ready}, {1'b1, 1'b1});
        drive2(0, 1, 3'd4, 0, 8'h00, 0, 1'b0);
        chk("par_clr_auto", {b2.ParErr, b2.Busy}, {1'b0, 1'b1});
        drive2(0, 1, 3'd0, 0, 8'h00, 0, 1'b0);
        drive2(0, 1, 3'd1, 0, 8'h03, 0, 1'b1);
        chk("par_load_no_set", {b2.ParErr, b2.IROut}, {1'b0, 16'h0003});
`endif

        // Random commands on the two-lane part against the reference model.
        for (int n = 0; n < 400; n++) begin
            bit r_rst, r_e, r_inv, r_par;
            int r_fs, r_lane, r_din, r;
            r_rst  = (n == 0) || ($urandom_range(0, 40) == 0);
            r_e    = ($urandom_range(0, 5) != 0);
            r      = $urandom_range(0, 15);
            r_fs   = (r == 0) ? 0 : (r <= 3) ? 1 : (r == 4) ? 2 : (r == 5) ? 3 :
                     (r <= 8) ? 4 : $urandom_range(5, 7);
            r_lane = $urandom_range(0, 1);
            r_din  = $urandom_range(0, 255);
            r_inv  = ($urandom_range(0, 2) != 0);
            r_par  = $urandom_range(0, 1);
            model_step(r_rst, r_e, r_fs, r_lane, r_din, r_inv, r_par);
            drive2(r_rst, r_e, 3'(r_fs), r_lane[0], 8'(r_din), r_inv, r_par);
            chk($sformatf("rand%0d", n), {b2.IROut, b2.Busy, b2.Ready, b2.ByteCnt},
                {16'(m_ir), m_fill, m_ready, m_cnt[0]});
`ifdef IR_PARITY_EN
            chk($sformatf("rand_par%0d", n), 64'(b2.ParErr), 64'(m_perr));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
